// File: rtl/sram_word_array.sv
// sram_word_array: single-port word memory (DEPTH x WIDTH) with a valid/ready
// request channel and a registered valid/ready read-response channel.
// Optional feature macro: SRAM_WORD_ARRAY_INIT_CLEAR_EN. When it is defined,
// the array is swept to zero after every reset, and requests are held off
// until the sweep finishes. When it is undefined, contents are unknown until
// they are written.
//
// Handshake rules: a beat transfers on a rising edge where valid && ready.
// The sender keeps valid and its payload stable until the transfer. The
// receiver's ready never depends on valid. rsp_rdata stays stable while
// rsp_valid && !rsp_ready.
module sram_word_array #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_rdata,
  output logic              init_done
);

`ifdef SRAM_WORD_ARRAY_INIT_CLEAR_EN
  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RESP = 2'd2
  } state_e;
  localparam state_e ST_RST = ST_INIT;
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd1,
    ST_RESP = 2'd2
  } state_e;
  localparam state_e ST_RST = ST_IDLE;
`endif

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  state_e             state_q;
  logic               rsp_valid_q;
  logic [WIDTH-1:0]   rsp_rdata_q;
`ifdef SRAM_WORD_ARRAY_INIT_CLEAR_EN
  logic [ADDR_W-1:0]  clr_cnt_q;
  logic               init_done_q;
`endif

  logic [WIDTH-1:0]   mem_q [DEPTH];

  logic               in_range;
  logic [ADDR_W-1:0]  acc_addr;
  logic [WIDTH-1:0]   rd_word;
  logic               req_fire;
  logic               rd_fire;
  logic               wr_fire;

  // Ready depends only on state and the consumer's ready; a held response
  // blocks new requests unless it is being taken this cycle. Gating with
  // rst_n keeps ready low while reset is asserted even when the reset state
  // is IDLE.
  assign req_ready = rst_n &&
                     ((state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready));

  assign req_fire  = req_valid && req_ready;
  assign rd_fire   = req_fire && !req_write;
  assign wr_fire   = req_fire && req_write;

  // Addresses beyond DEPTH are accepted. Writes to them are dropped and reads
  // of them return zero. The array index is clamped so that it never leaves
  // the array.
  assign in_range  = ({1'b0, req_addr} < DEPTH_X);
  assign acc_addr  = in_range ? req_addr : '0;
  assign rd_word   = in_range ? mem_q[acc_addr] : '0;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

`ifdef SRAM_WORD_ARRAY_INIT_CLEAR_EN
  assign init_done = init_done_q;
`else
  assign init_done = 1'b1;
`endif

  // Control FSM: clear sweep (optional), idle, and response-held states,
  // together with the registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RST;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef SRAM_WORD_ARRAY_INIT_CLEAR_EN
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
`endif
    end else begin
      case (state_q)
`ifdef SRAM_WORD_ARRAY_INIT_CLEAR_EN
        ST_INIT: begin
          if (clr_cnt_q == CLR_LAST) begin
            state_q     <= ST_IDLE;
            init_done_q <= 1'b1;
          end else begin
            clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
          end
        end
`endif
        ST_IDLE: begin
          if (rd_fire) begin
            rsp_rdata_q <= rd_word;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          // A read can only be accepted here when rsp_ready is high. In that
          // case the old word leaves and the new word replaces it in the
          // same cycle.
          if (rd_fire) begin
            rsp_rdata_q <= rd_word;
          end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: the clear sweep has priority, then accepted in-range
  // writes. There is deliberately no reset, so contents survive rst_n.
  always_ff @(posedge clk) begin
`ifdef SRAM_WORD_ARRAY_INIT_CLEAR_EN
    if (state_q == ST_INIT) begin
      mem_q[clr_cnt_q] <= '0;
    end else
`endif
    if (wr_fire && in_range) begin
      mem_q[acc_addr] <= req_wdata;
    end
  end

endmodule

// File: tb/tb_sram_word_array.sv
// Bench for sram_word_array. It checks a 16-word instance against a
// behavioural memory model and a response queue. It uses a 10-word instance
// for out-of-range addressing. Both instances share the clock and the reset.
module tb_sram_word_array;
  localparam int W   = 8;
  localparam int D   = 16;
  localparam int AW  = 4;
  localparam int D10 = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid, req_ready, req_write, rsp_valid, rsp_ready, init_done;
  logic [AW-1:0] req_addr;
  logic [W-1:0]  req_wdata, rsp_rdata;

  logic          b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_ready, b_init_done;
  logic [AW-1:0] b_req_addr;
  logic [W-1:0]  b_req_wdata, b_rsp_rdata;

  sram_word_array #(.WIDTH(W), .DEPTH(D)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_done(init_done)
  );

  sram_word_array #(.WIDTH(W), .DEPTH(D10)) u_dut10 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .init_done(b_init_done)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: the word contents of each instance and the responses still owed.
  logic [W-1:0] model_mem [D];
  logic [W-1:0] b_mem [D10];
  logic [W-1:0] exp_q [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1'b1;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      n++;
      step();
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    step();
    req_valid = 1'b0; req_write = 1'b0;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL write_no_rsp addr=%0d got rsp_valid=%b want 0", a, rsp_valid);
    end
    model_mem[a] = d;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== model_mem[a]) begin
      bad++; $display("FAIL read addr=%0d got valid=%b data=%h want valid=1 data=%h",
                      a, rsp_valid, rsp_rdata, model_mem[a]);
    end
    step();
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL read_drop addr=%0d got rsp_valid=%b want 0", a, rsp_valid);
    end
  endtask

  task automatic b_write(input logic [AW-1:0] a, input logic [W-1:0] d);
    b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = a; b_req_wdata = d;
    step();
    b_req_valid = 1'b0; b_req_write = 1'b0;
    if (a < D10) b_mem[a] = d;
  endtask

  task automatic b_read(input logic [AW-1:0] a, input logic [W-1:0] e);
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = a; b_rsp_ready = 1'b1;
    step();
    b_req_valid = 1'b0;
    total++;
    if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== e) begin
      bad++; $display("FAIL d10_read addr=%0d got valid=%b data=%h want valid=1 data=%h",
                      a, b_rsp_valid, b_rsp_rdata, e);
    end
    step();
  endtask

  task automatic test_reset();
    int n;
    idle_inputs();
    #1 rst_n = 1'b0;
    step(); step();
    total++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== '0) begin
      bad++; $display("FAIL reset_outputs got ready=%b valid=%b data=%h want 0 0 00",
                      req_ready, rsp_valid, rsp_rdata);
    end
`ifdef SRAM_WORD_ARRAY_INIT_CLEAR_EN
    total++;
    if (init_done !== 1'b0) begin
      bad++; $display("FAIL reset_init_done got=%b want 0", init_done);
    end
    rst_n = 1'b1;
    wait_init(n);
    total++;
    if (n != D) begin
      bad++; $display("FAIL init_cycles got=%0d want %0d", n, D);
    end
    total++;
    if (init_done !== 1'b1) begin
      bad++; $display("FAIL init_done_rise got=%b want 1", init_done);
    end
    for (int i = 0; i < D; i++) model_mem[i] = '0;
    for (int i = 0; i < D10; i++) b_mem[i] = '0;
`else
    rst_n = 1'b1;
    #1;
    total++;
    if (req_ready !== 1'b1 || init_done !== 1'b1) begin
      bad++; $display("FAIL ready_after_release got ready=%b init_done=%b want 1 1",
                      req_ready, init_done);
    end
    step();
`endif
  endtask

  task automatic test_init_zero();
    for (int i = 0; i < D; i++) do_read(AW'(i));
  endtask

  task automatic test_fill();
    for (int i = 0; i < D; i++) do_write(AW'(i), W'($urandom_range(0, 255)));
  endtask

  task automatic test_raw();
    do_write(4'd3, 8'hA5);
    do_read(4'd3);
  endtask

  task automatic test_backpressure();
    do_write(4'd5, 8'h3C);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd5; rsp_ready = 1'b0;
    step();
    // A write offered during the stall must not be taken.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd6; req_wdata = ~model_mem[6];
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h3C || req_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold cyc=%0d got valid=%b data=%h ready=%b want 1 3c 0",
                        i, rsp_valid, rsp_rdata, req_ready);
      end
      step();
    end
    req_valid = 1'b0; req_write = 1'b0; rsp_ready = 1'b1;
    step();
    total++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 8'h3C) begin
      bad++; $display("FAIL bp_release got valid=%b data=%h want 0 3c", rsp_valid, rsp_rdata);
    end
    do_read(4'd6);
  endtask

  task automatic test_back_to_back();
    do_write(4'd0, 8'h11);
    do_write(4'd1, 8'h22);
    do_write(4'd2, 8'h33);
    rsp_ready = 1'b1; req_valid = 1'b1; req_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_addr = AW'(i);
      #1;
      total++;
      if (req_ready !== 1'b1) begin
        bad++; $display("FAIL b2b_ready cyc=%0d got=%b want 1", i, req_ready);
      end
      step();
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== model_mem[i]) begin
        bad++; $display("FAIL b2b_data cyc=%0d got valid=%b data=%h want 1 %h",
                        i, rsp_valid, rsp_rdata, model_mem[i]);
      end
    end
    req_valid = 1'b0;
    step();
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_drop got=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_random();
    logic rv, wr, rr, exp_ready;
    logic [AW-1:0] a;
    logic [W-1:0] d;
    exp_q = {};
    for (int c = 0; c < 300; c++) begin
      rv = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 3) == 0);
      rr = ($urandom_range(0, 3) != 0);
      a  = AW'($urandom_range(0, D - 1));
      d  = W'($urandom_range(0, 255));
      req_valid = rv; req_write = wr; req_addr = a; req_wdata = d; rsp_ready = rr;
      #1;
      exp_ready = (exp_q.size() == 0) || rr;
      total++;
      if (req_ready !== exp_ready) begin
        bad++; $display("FAIL rnd_ready cyc=%0d got=%b want %b", c, req_ready, exp_ready);
      end
      if (exp_q.size() != 0 && rr) void'(exp_q.pop_front());
      if (rv && exp_ready) begin
        if (wr) model_mem[a] = d;
        else    exp_q.push_back(model_mem[a]);
      end
      step();
      total++;
      if (rsp_valid !== (exp_q.size() != 0)) begin
        bad++; $display("FAIL rnd_valid cyc=%0d got=%b want %b", c, rsp_valid, exp_q.size() != 0);
      end else if (exp_q.size() != 0 && rsp_rdata !== exp_q[0]) begin
        bad++; $display("FAIL rnd_data cyc=%0d got=%h want %h", c, rsp_rdata, exp_q[0]);
      end
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    step();
    exp_q = {};
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL rnd_drain got=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_out_of_range();
`ifndef SRAM_WORD_ARRAY_INIT_CLEAR_EN
    for (int i = 0; i < D10; i++) b_write(AW'(i), W'($urandom_range(0, 255)));
`endif
    b_write(4'd12, 8'hFF);
    b_read(4'd12, 8'h00);
    for (int i = 0; i < D10; i++) b_read(AW'(i), b_mem[i]);
  endtask

  task automatic test_reset_mid();
    int n;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd3; rsp_ready = 1'b0;
    step();
    req_valid = 1'b0;
    total++;
    if (rsp_valid !== 1'b1) begin
      bad++; $display("FAIL mid_pending got=%b want 1", rsp_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_rdata !== '0) begin
      bad++; $display("FAIL rst_async got valid=%b ready=%b data=%h want 0 0 00",
                      rsp_valid, req_ready, rsp_rdata);
    end
    rsp_ready = 1'b1;
    step();
    rst_n = 1'b1;
`ifdef SRAM_WORD_ARRAY_INIT_CLEAR_EN
    repeat (7) step();
    rst_n = 1'b0;
    #1;
    total++;
    if (init_done !== 1'b0 || req_ready !== 1'b0) begin
      bad++; $display("FAIL sweep_reset got init_done=%b ready=%b want 0 0", init_done, req_ready);
    end
    step();
    rst_n = 1'b1;
    wait_init(n);
    total++;
    if (n != D) begin
      bad++; $display("FAIL restart_cycles got=%0d want %0d", n, D);
    end
    for (int i = 0; i < D; i++) model_mem[i] = '0;
`else
    #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL mid_release_ready got=%b want 1", req_ready);
    end
    step();
`endif
    do_read(4'd3);
  endtask

  initial begin
    test_reset();
`ifdef SRAM_WORD_ARRAY_INIT_CLEAR_EN
    test_init_zero();
`endif
    test_fill();
    test_raw();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_out_of_range();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_word_array.md
# sram_word_array

- Clocked, parametrised word-organised memory built from storage cells: `DEPTH` words of `WIDTH` bits.
- Single port with a valid/ready request channel and a valid/ready read-response channel.
- Sits between bus-side control logic and the cell array; replaces per-bit `sel`/`read` wiring with address decoding, a handshake and registered read data.

## Interface

Parameters:
- `WIDTH`, 8, data bits per word (≥1)
- `DEPTH`, 16, number of words (≥2, need not be a power of two)
- `ADDR_W`, `$clog2(DEPTH)`, address width (derived; do not override)

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge
- `rst_n`  input  1  asynchronous, active-low reset; deassertion synchronous to `clk` is the integrator's job
- `req_valid`  input  1  request present
- `req_ready`  output  1  request accepted when `req_valid && req_ready` at a rising edge
- `req_write`  input  1  1 = write, 0 = read
- `req_addr`  input  `ADDR_W`  word address
- `req_wdata`  input  `WIDTH`  write data
- `rsp_valid`  output  1  read data valid
- `rsp_ready`  input  1  consumer takes the response when `rsp_valid && rsp_ready` at a rising edge
- `rsp_rdata`  output  `WIDTH`  read data; stable while `rsp_valid && !rsp_ready`
- `init_done`  output  1  array usable

## Operation

- FSM states:
  - INIT: clear sweep; present only with the macro, see Configuration.
  - IDLE: no response pending.
  - RESP: response held.
- Reset (`rst_n` low) values:
  - `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0.
  - `init_done`=0 with the macro, 1 without it.
  - Internal clear counter = 0.
  - State = INIT with the macro, IDLE without it.
- `req_ready` = (state==IDLE) || (state==RESP && `rsp_ready`). It is combinational from state and `rsp_ready` only, never from `req_valid`.
- Accepted write: `mem[req_addr] <= req_wdata` at the accepting edge. No response is produced. State is unchanged, except RESP→IDLE when the pending response is consumed in the same cycle.
- Accepted read: `rsp_rdata <= mem[req_addr]`, `rsp_valid <= 1`, state→RESP.
- RESP with `rsp_ready`=1 and no new read: `rsp_valid <= 0`, state→IDLE. `rsp_rdata` holds its last value.
- RESP with `rsp_ready`=1 and a new read accepted in the same cycle: `rsp_valid` stays 1, `rsp_rdata` takes the new word, state stays RESP. This gives back-to-back reads at full rate.
- Out-of-range address (`req_addr` ≥ `DEPTH`):
  - Write: accepted and discarded; no array word changes.
  - Read: accepted and returns all-zero data.
- Memory contents are not affected by `rst_n` except through the INIT sweep.

## Timing

- Read latency is 1 cycle: request accepted at edge N gives `rsp_valid`=1 and data after edge N.
- Read-after-write: a write accepted at edge N and a read of the same address accepted at edge N+1 return the new data.
- Port is single-ported; a write and a read never occur in the same cycle.
- Backpressure: with `rsp_ready`=0, `rsp_valid`, `rsp_rdata` and `req_ready`=0 hold indefinitely.
- `rst_n` asserted mid-transaction: outputs go to reset values immediately (asynchronously). A pending response is lost. A write at the same edge as reset assertion is not guaranteed.

## Configuration

- Macro: `SRAM_WORD_ARRAY_INIT_CLEAR_EN`.
- Defined:
  - After reset release the FSM sits in INIT for exactly `DEPTH` cycles, writing zero to address 0..`DEPTH`-1, one word per cycle.
  - `req_ready`=0 throughout INIT.
  - `init_done` rises together with the transition to IDLE and stays 1 until the next reset.
  - Reset during INIT restarts the sweep at address 0.
- Undefined:
  - No INIT state and no clear counter.
  - `init_done` is tied to 1.
  - `req_ready`=1 in the first cycle after reset release.
  - Array contents are undefined (X) until written.

## Test plan

- Macro defined, WIDTH=8, DEPTH=16: release reset → `req_ready`=0 for exactly 16 cycles; `init_done` rises after that; reading every address returns 0x00.
- Write 0xA5 to address 3 at edge N, read address 3 at edge N+1 → `rsp_valid`=1 after edge N+1 with `rsp_rdata`=0xA5; no response is produced for the write.
- Hold `rsp_ready`=0 for 5 cycles after a read of 0x3C → `rsp_valid`, `rsp_rdata`=0x3C and `req_ready`=0 stable for all 5 cycles; raise `rsp_ready` → `rsp_valid` drops next edge.
- `rsp_ready`=1 with reads of addresses 0,1,2 on consecutive cycles (contents 0x11, 0x22, 0x33) → `rsp_valid` continuously 1 for 3 cycles with data 0x11, 0x22, 0x33.
- DEPTH=10: write 0xFF to address 12, then read 12 → 0x00; read addresses 0–9 → unchanged contents.
- Assert `rst_n` while a response is pending and during the INIT sweep at address 7 → `rsp_valid`=0 immediately; after release the sweep restarts and takes the full 16 cycles.
